// File: rtl/sev_seg_scan_if.sv
//==============================================================================
// Module      : sev_seg_scan_if
// Description : Bundle between a display controller and the 4-digit
//               seven-segment scanner.
//                 en        - scan enable (0 freezes scan, blanks digits)
//                 load      - single-cycle strobe capturing value
//                 value     - four hex nibbles, [3:0] shown on digit 0
//                 nibble    - hex code of the active digit
//                 digit_sel - index of the active digit, 0..3
//                 digit_an  - active-low one-hot digit enables
//               master drives en/load/value; slave (the scanner) drives
//               nibble/digit_sel/digit_an.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sev_seg_scan_if;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  nibble;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_an;

    modport master (
        output en, load, value,
        input  nibble, digit_sel, digit_an
    );

    modport slave (
        input  en, load, value,
        output nibble, digit_sel, digit_an
    );
endinterface

`default_nettype wire

// File: rtl/sev_seg_scan.sv
//==============================================================================
// Module      : sev_seg_scan
// Description : Time-multiplexed scanner for a 4-digit seven-segment display.
//               A prescaler divides clk into digit slots of CLK_DIV cycles;
//               each slot presents one nibble of the captured value together
//               with an active-low one-hot anode enable.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - sev_seg_scan_if.slave (en, load, value in;
//                      nibble, digit_sel, digit_an out)
// Parameters  : CLK_DIV - clk cycles per digit slot, 1..65535
// Config      : SEV_SEG_LEADING_ZERO_BLANK_EN - when defined, leading-zero
//               digits (n>0 with value_q[15:4n]==0) are kept dark.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sev_seg_scan #(
    parameter int CLK_DIV = 50000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sev_seg_scan_if.slave  bus
);

    localparam int                c_PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(CLK_DIV - 1);

    logic [15:0]       r_value_q;
    logic [c_PS_W-1:0] r_prescaler;
    logic [1:0]        r_digit;

    logic              w_wrap;
    logic [3:0]        w_blank;
    logic [3:0]        w_an_scan;

    // With CLK_DIV=1 the prescaler is a single bit pinned at zero, so the
    // wrap condition holds every enabled cycle.
    assign w_wrap = (r_prescaler == c_PS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q   <= 16'h0000;
            r_prescaler <= '0;
            r_digit     <= 2'd0;
        end else begin
            if (bus.load) begin
                r_value_q <= bus.value;
            end
            if (bus.en) begin
                if (w_wrap) begin
                    r_prescaler <= '0;
                    r_digit     <= r_digit + 2'd1;
                end else begin
                    r_prescaler <= r_prescaler + 1'b1;
                end
            end
        end
    end

    // Nibble comes purely from registers so no input glitch reaches the
    // segment decoder.
    assign bus.nibble    = r_value_q[{r_digit, 2'b00} +: 4];
    assign bus.digit_sel = r_digit;

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    // Digit n is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    assign w_blank[0] = 1'b0;
    assign w_blank[1] = (r_value_q[15:4]  == 12'h000);
    assign w_blank[2] = (r_value_q[15:8]  == 8'h00);
    assign w_blank[3] = (r_value_q[15:12] == 4'h0);
`else
    assign w_blank = 4'b0000;
`endif

    // Blanking only ever raises bits, so at most one anode can be low.
    assign w_an_scan    = ~(4'b0001 << r_digit) | w_blank;
    assign bus.digit_an = bus.en ? w_an_scan : 4'b1111;

endmodule

`default_nettype wire
